// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between the MIPS32 datapath and a word-organised RAM
//   (2^ADDR_BITS x 32, combinational read, write on rising edge).
//   Byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests become word accesses.
//   Sub-word stores run a read-modify-write (RMW_READ then WRITE).
//   Misaligned, illegal-size and out-of-range requests are rejected through
//   a one-cycle ERR state that never touches the RAM.
//
// Ports
//   clk_i, rst_i       clock (rising edge), synchronous active-high reset
//   req_i              request strobe, sampled only while idle
//   write_i            1 = store, 0 = load
//   size_i             00 byte, 01 half, 10 word, 11 illegal
//   signed_i           loads: 1 = sign-extend, 0 = zero-extend
//   addr_i, wdata_i    byte address, right-justified store data
//   busy_o             high whenever not idle
//   done_o, error_o    one-cycle completion pulse and reject flag
//   rdata_o            load result, held until the next load
//   ram_addr_o         RAM word address
//   ram_we_o           RAM write enable
//   ram_wdata_o        RAM write data
//   ram_rdata_i        RAM read data (combinational)
module mem_access_unit #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 write_i,
    input  logic [1:0]           size_i,
    input  logic                 signed_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [31:0]          rdata_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    output logic                 ram_we_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t               state_q;
    logic                 write_q;
    logic [1:0]           size_q;
    logic                 signed_q;
    logic [ADDR_BITS+1:0] addr_q;   // only in-range bits are ever needed
    logic [31:0]          wdata_q;
    logic [31:0]          merge_q;
    logic                 done_q;
    logic                 error_q;
    logic [31:0]          rdata_q;

    logic                 acc_err;
    logic [7:0]           lane_b;
    logic [15:0]          lane_h;
    logic [31:0]          rdata_d;
    logic [31:0]          merge_d;

    // Request rejection, evaluated on the live request inputs at acceptance.
    always_comb begin
        acc_err = 1'b0;
        if (size_i == SZ_ILL)                           acc_err = 1'b1;
        if (size_i == SZ_HALF && addr_i[0])             acc_err = 1'b1;
        if (size_i == SZ_WORD && addr_i[1:0] != 2'b00)  acc_err = 1'b1;
        if (addr_i[31:ADDR_BITS+2] != '0)               acc_err = 1'b1;
    end

    // Lane extraction / extension for loads (little-endian lanes).
    always_comb begin
        lane_b  = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h  = ram_rdata_i[{addr_q[1], 4'b0000} +: 16];
        rdata_d = ram_rdata_i;
        case (size_q)
            SZ_BYTE: rdata_d = {{24{signed_q & lane_b[7]}}, lane_b};
            SZ_HALF: rdata_d = {{16{signed_q & lane_h[15]}}, lane_h};
            default: rdata_d = ram_rdata_i;
        endcase
    end

    // Sub-word store merge: old word with the addressed lane replaced.
    always_comb begin
        merge_d = ram_rdata_i;
        if (size_q == SZ_BYTE)
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == SZ_HALF)
            merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        write_q  <= write_i;
                        size_q   <= size_i;
                        signed_q <= signed_i;
                        addr_q   <= addr_i[ADDR_BITS+1:0];
                        wdata_q  <= wdata_i;
                        if (acc_err)              state_q <= S_ERR;
                        else if (!write_i)        state_q <= S_LOAD;
                        else if (size_i == SZ_WORD) state_q <= S_WRITE;
                        else                      state_q <= S_RMW_READ;
                    end
                end
                S_LOAD: begin
                    rdata_q <= rdata_d;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_RMW_READ: begin
                    merge_q <= merge_d;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign rdata_o     = rdata_q;
    assign ram_addr_o  = addr_q[ADDR_BITS+1:2];
    // Gate with reset so an abandoned store cannot land on the reset edge.
    assign ram_we_o    = (state_q == S_WRITE) && write_q && !rst_i;
    assign ram_wdata_o = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int AB = 14;

    logic          clk = 1'b0;
    logic          rst, req, wr, sgn;
    logic [1:0]    size;
    logic [31:0]   addr, wdata;
    logic          busy, done, err;
    logic [31:0]   rdata;
    logic [AB-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [31:0]   mem [0:(1<<AB)-1];
    int            we_total = 0;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_BITS(AB)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .size_i(size),
        .signed_i(sgn), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
        .done_o(done), .error_o(err), .rdata_o(rdata), .ram_addr_o(ram_addr),
        .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Bench-side RAM: combinational read, write on rising edge.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from idle; report cycles to Done (cycle 1 = first
    // cycle after the accepting edge), Error/RData at Done, write strobes
    // seen and the cycle of the last one.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int wn, output int wc);
        wr = w; size = sz; sgn = s; addr = a; wdata = d; req = 1'b1;
        wn = 0; wc = 0;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        if (ram_we) begin wn++; wc = lat; end
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (ram_we) begin wn++; wc = lat; end
        end
        e = err; rd = rdata;
    endtask

    int          lat, wn, wc, wbase;
    logic        e;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < (1<<AB); i++) mem[i] = 32'h0;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_we", {31'b0, ram_we}, 32'h0);
        chk("rst_raddr", {18'b0, ram_addr}, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SW then LW
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, e, rd, wn, wc);
        chk("sw_lat", lat, 2); chk("sw_err", {31'b0, e}, 0);
        chk("sw_wn", wn, 1); chk("sw_mem", mem[4], 32'hDEADBEEF);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd, wn, wc);
        chk("lw_lat", lat, 2); chk("lw_err", {31'b0, e}, 0);
        chk("lw_rdata", rd, 32'hDEADBEEF); chk("lw_wn", wn, 0);
        chk("done_busy", {31'b0, busy}, 0);

        // Sub-word loads
        do_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e, rd, wn, wc);
        chk("lb_lat", lat, 2); chk("lb_rdata", rd, 32'hFFFFFFBE);
        do_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, e, rd, wn, wc);
        chk("lbu_rdata", rd, 32'h000000BE);
        do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, e, rd, wn, wc);
        chk("lb3_rdata", rd, 32'hFFFFFFDE);
        do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, e, rd, wn, wc);
        chk("lhu_rdata", rd, 32'h0000BEEF);
        do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, e, rd, wn, wc);
        chk("lh_rdata", rd, 32'hFFFFDEAD);
        do_op(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, e, rd, wn, wc);
        chk("lw_signed", rd, 32'hDEADBEEF);

        // SB read-modify-write
        do_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h12, lat, e, rd, wn, wc);
        chk("sb_lat", lat, 3); chk("sb_wn", wn, 1); chk("sb_wc", wc, 2);
        chk("sb_mem", mem[4], 32'h12ADBEEF);
        chk("sb_rdata_hold", rd, 32'hDEADBEEF);
        // SH into upper half
        do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h5678, lat, e, rd, wn, wc);
        chk("sh_lat", lat, 3); chk("sh_mem", mem[4], 32'h5678BEEF);

        // Rejected requests
        wbase = we_total;
        do_op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, e, rd, wn, wc);
        chk("e_lh_lat", lat, 2); chk("e_lh_err", {31'b0, e}, 1);
        chk("e_lh_rdata", rd, 32'hDEADBEEF);
        do_op(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, lat, e, rd, wn, wc);
        chk("e_sw_lat", lat, 2); chk("e_sw_err", {31'b0, e}, 1);
        do_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e, rd, wn, wc);
        chk("e_sz_lat", lat, 2); chk("e_sz_err", {31'b0, e}, 1);
        do_op(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, lat, e, rd, wn, wc);
        chk("e_oor_lat", lat, 2); chk("e_oor_err", {31'b0, e}, 1);
        do_op(1'b1, 2'b00, 1'b0, 32'h0002_0004, 32'h99, lat, e, rd, wn, wc);
        chk("e_sboor_err", {31'b0, e}, 1);
        chk("e_no_we", we_total - wbase, 0);
        chk("e_mem", mem[4], 32'h5678BEEF);
        @(posedge clk); #1;
        chk("err_clears", {30'b0, err, done}, 0);

        // Reset in RMW_READ of SH 0x20
        mem[8] = 32'h11223344;
        wbase = we_total;
        wr = 1'b1; size = 2'b01; sgn = 1'b0; addr = 32'h20; wdata = 32'hAAAA; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rr_busy", {31'b0, busy}, 0);
        chk("rr_done", {31'b0, done}, 0);
        @(posedge clk); #1;
        chk("rr_done2", {31'b0, done}, 0);
        chk("rr_mem", mem[8], 32'h11223344);
        chk("rr_no_we", we_total - wbase, 0);

        // Reset in WRITE of SB 0x20: write enable gated off
        wr = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h55; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rw_we_before", {31'b0, ram_we}, 1);
        rst = 1'b1; #1;
        chk("rw_we_gated", {31'b0, ram_we}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rw_mem", mem[8], 32'h11223344);
        chk("rw_done", {31'b0, done}, 0);
        @(posedge clk); #1;

        // Back-to-back loads with req held high
        mem[0] = 32'hA0A0A0A0; mem[1] = 32'hA1A1A1A1; mem[2] = 32'hA2A2A2A2;
        wr = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h0; req = 1'b1;
        @(posedge clk); #1;              // accept 0x0
        chk("bb_busy0", {31'b0, busy}, 1);
        addr = 32'h4;
        @(posedge clk); #1;              // Done 0x0, idle
        chk("bb_done0", {31'b0, done}, 1); chk("bb_rd0", rdata, 32'hA0A0A0A0);
        @(posedge clk); #1;              // accept 0x4
        chk("bb_nd1", {31'b0, done}, 0);
        addr = 32'h8;
        @(posedge clk); #1;
        chk("bb_done1", {31'b0, done}, 1); chk("bb_rd1", rdata, 32'hA1A1A1A1);
        @(posedge clk); #1;              // accept 0x8
        req = 1'b0;
        @(posedge clk); #1;
        chk("bb_done2", {31'b0, done}, 1); chk("bb_rd2", rdata, 32'hA2A2A2A2);
        @(posedge clk); #1;
        chk("bb_idle", {30'b0, busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end
endmodule
